// File: rtl/dmem_responder_if.sv
// Data-memory bus between the datapath and dmem_responder.
// Request strobes are active-low.
interface dmem_responder_if;
  logic        mem_enable;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        stall;
  logic        err;

  modport master (
    output mem_enable, mem_read, mem_write,
    output addr, wdata,
    input  rdata, stall, err
  );

  modport slave (
    input  mem_enable, mem_read, mem_write,
    input  addr, wdata,
    output rdata, stall, err
  );
endinterface

// File: rtl/dmem_responder.sv
// Word-wide data memory with fixed access latency.
// Stalls the datapath until each latched access commits.
module dmem_responder #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input logic            clk,
  input logic            rst,
  dmem_responder_if.slave bus
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t state;
  state_t state_n;

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_n;

  logic [IW-1:0] idx;
  logic          wr;
  logic [31:0]   wd;
  logic [31:0]   rdata;
  logic          err;
  logic          stall;
  logic [31:0]   mem [DEPTH];

  logic en_lo;
  logic one_op;
  logic aligned;
  logic legal;
  logic bad;
  logic accept;
  logic commit;
  logic unused_addr;

  assign en_lo   = !bus.mem_enable;
  assign one_op  = (!bus.mem_read) ^ (!bus.mem_write);
  assign aligned = (bus.addr[1:0] == 2'b00);
  assign legal   = en_lo && one_op && aligned;
  assign bad     = en_lo && !(one_op && aligned);

  assign unused_addr = ^bus.addr[31:IW+2];

  assign bus.rdata = rdata;
  assign bus.err   = err;
  assign bus.stall = stall;

  // State and latency counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // Next-state, counter and stall decode
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    accept  = 1'b0;
    commit  = 1'b0;
    stall   = 1'b0;
    unique case (state)
      IDLE: begin
        if (legal) begin
          accept  = 1'b1;
          stall   = 1'b1;
          cnt_n   = CW'(LATENCY - 1);
          state_n = BUSY;
        end
      end
      BUSY: begin
        stall = 1'b1;
        if (cnt != '0) begin
          cnt_n = cnt - 1'b1;
        end else begin
          commit  = 1'b1;
          state_n = DONE;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Latch the request so later input changes are ignored
  always_ff @(posedge clk) begin
    if (accept) begin
      wr  <= !bus.mem_write;
      idx <= bus.addr[IW+1:2];
      wd  <= bus.wdata;
    end
  end

  // Load data and illegal-request pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
      err   <= 1'b0;
    end else begin
      err <= (state == IDLE) && bad;
      if (commit && !wr) begin
        rdata <= mem[idx];
      end
    end
  end

  // Array write; a reset on the commit edge drops the store
  always_ff @(posedge clk) begin
    if (commit && wr && !rst) begin
      mem[idx] <= wd;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized self-checking bench for dmem_responder.
// Reference model tracks memory and load data by word address.
module tb_dmem_responder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [31:0] ref_mem [256];
  logic [31:0] ref_rdata;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_responder_if bus();

  dmem_responder #(.DEPTH(256), .LATENCY(2)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  function automatic int widx(input logic [31:0] a);
    return int'((a / 4) % 256);
  endfunction

  task automatic idle();
    bus.mem_enable = 1'b1;
    bus.mem_read   = 1'b1;
    bus.mem_write  = 1'b1;
  endtask

  task automatic drive(input bit w, input logic [31:0] a, input logic [31:0] d);
    bus.mem_enable = 1'b0;
    bus.mem_read   = w;
    bus.mem_write  = !w;
    bus.addr       = a;
    bus.wdata      = d;
  endtask

  // Runs one access; returns stall length, DONE-cycle rdata and start cycle
  task automatic run_access(input bit w, input logic [31:0] a,
                            input logic [31:0] d, output int ns,
                            output logic [31:0] rd, output int start);
    ns = 0;
    start = -1;
    drive(w, a, d);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.stall === 1'b1) begin
        if (start < 0) start = cyc;
        ns++;
      end else begin
        break;
      end
    end
    rd = bus.rdata;
    if (w) ref_mem[widx(a)] = d;
    else ref_rdata = ref_mem[widx(a)];
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    ref_rdata = '0;
    total++;
    if (bus.rdata !== 32'h0) begin
      bad++; $display("FAIL reset_rdata: got %h want %h", bus.rdata, 32'h0);
    end
    total++;
    if (bus.stall !== 1'b0) begin
      bad++; $display("FAIL reset_stall: got %b want 0", bus.stall);
    end
    total++;
    if (bus.err !== 1'b0) begin
      bad++; $display("FAIL reset_err: got %b want 0", bus.err);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_write_read();
    int ns, st;
    logic [31:0] rd;
    run_access(1'b1, 32'h10, 32'hDEADBEEF, ns, rd, st);
    total++;
    if (ns != 3) begin
      bad++; $display("FAIL wr_stall_len: got %0d want 3", ns);
    end
    @(negedge clk);
    total++;
    if (bus.stall !== 1'b0) begin
      bad++; $display("FAIL wr_stall_after: got %b want 0", bus.stall);
    end
    @(posedge clk);
    #1;
    run_access(1'b0, 32'h10, 32'h0, ns, rd, st);
    total++;
    if (ns != 3) begin
      bad++; $display("FAIL rd_stall_len: got %0d want 3", ns);
    end
    total++;
    if (rd !== ref_rdata) begin
      bad++; $display("FAIL rd_data: got %h want %h", rd, ref_rdata);
    end
    run_access(1'b1, 32'h14, 32'h01234567, ns, rd, st);
    total++;
    if (rd !== ref_rdata) begin
      bad++; $display("FAIL rd_hold: got %h want %h", rd, ref_rdata);
    end
  endtask

  task automatic test_wrap();
    int ns, st;
    logic [31:0] rd;
    run_access(1'b1, 32'h0, 32'h11111111, ns, rd, st);
    run_access(1'b1, 32'h400, 32'h22222222, ns, rd, st);
    run_access(1'b0, 32'h0, 32'h0, ns, rd, st);
    total++;
    if (rd !== ref_rdata) begin
      bad++; $display("FAIL wrap: got %h want %h", rd, ref_rdata);
    end
  endtask

  task automatic test_illegal();
    int ns, st;
    logic [31:0] rd;
    for (int k = 0; k < 3; k++) begin
      bus.mem_enable = 1'b0;
      bus.addr  = (k == 0) ? 32'h13 : 32'h10;
      bus.wdata = 32'h12345678;
      bus.mem_read  = (k == 2);
      bus.mem_write = (k != 1);
      @(negedge clk);
      total++;
      if (bus.stall !== 1'b0) begin
        bad++; $display("FAIL ill_stall%0d: got %b want 0", k, bus.stall);
      end
      @(posedge clk);
      #1;
      idle();
      @(negedge clk);
      total++;
      if (bus.err !== 1'b1) begin
        bad++; $display("FAIL ill_err%0d: got %b want 1", k, bus.err);
      end
      @(negedge clk);
      total++;
      if (bus.err !== 1'b0) begin
        bad++; $display("FAIL ill_err_end%0d: got %b want 0", k, bus.err);
      end
      @(posedge clk);
      #1;
    end
    run_access(1'b0, 32'h10, 32'h0, ns, rd, st);
    total++;
    if (rd !== ref_rdata) begin
      bad++; $display("FAIL ill_nowrite: got %h want %h", rd, ref_rdata);
    end
    bus.mem_enable = 1'b1;
    bus.mem_read   = 1'b0;
    bus.addr       = 32'h10;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (bus.stall !== 1'b0 || bus.err !== 1'b0) begin
        bad++;
        $display("FAIL disabled: got stall=%b err=%b want 0 0", bus.stall, bus.err);
      end
    end
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic test_reset_mid_write();
    int ns, st;
    logic [31:0] rd;
    run_access(1'b1, 32'h20, 32'h5, ns, rd, st);
    drive(1'b1, 32'h20, 32'hAAAAAAAA);
    @(posedge clk);
    #1;
    rst = 1'b1;
    idle();
    @(posedge clk);
    @(negedge clk);
    ref_rdata = '0;
    total++;
    if (bus.stall !== 1'b0) begin
      bad++; $display("FAIL rst_mid_stall: got %b want 0", bus.stall);
    end
    total++;
    if (bus.rdata !== ref_rdata) begin
      bad++; $display("FAIL rst_mid_rdata: got %h want %h", bus.rdata, ref_rdata);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    run_access(1'b0, 32'h20, 32'h0, ns, rd, st);
    total++;
    if (rd !== ref_rdata) begin
      bad++; $display("FAIL rst_mid_abort: got %h want %h", rd, ref_rdata);
    end
  endtask

  task automatic test_perturb();
    int ns, st;
    logic [31:0] rd;
    run_access(1'b1, 32'h34, 32'h0BADF00D, ns, rd, st);
    for (int k = 0; k < 2; k++) begin
      drive(k == 0, 32'h30, 32'hCAFEF00D);
      @(posedge clk);
      #1;
      bus.addr  = 32'h34;
      bus.wdata = 32'hFFFFFFFF;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (bus.stall !== 1'b1) break;
      end
      if (k == 0) ref_mem[widx(32'h30)] = 32'hCAFEF00D;
      else ref_rdata = ref_mem[widx(32'h30)];
      total++;
      if (bus.rdata !== ref_rdata) begin
        bad++; $display("FAIL perturb%0d: got %h want %h", k, bus.rdata, ref_rdata);
      end
      @(posedge clk);
      #1;
      idle();
    end
    run_access(1'b0, 32'h34, 32'h0, ns, rd, st);
    total++;
    if (rd !== ref_rdata) begin
      bad++; $display("FAIL perturb_other: got %h want %h", rd, ref_rdata);
    end
  endtask

  task automatic test_back_to_back();
    int ns1, ns2, s1, s2;
    logic [31:0] rd;
    run_access(1'b0, 32'h10, 32'h0, ns1, rd, s1);
    run_access(1'b0, 32'h30, 32'h0, ns2, rd, s2);
    total++;
    if (s2 - s1 != 4) begin
      bad++; $display("FAIL b2b_spacing: got %0d want 4", s2 - s1);
    end
    total++;
    if (ns1 != 3 || ns2 != 3) begin
      bad++; $display("FAIL b2b_stall: got %0d/%0d want 3/3", ns1, ns2);
    end
    total++;
    if (rd !== ref_rdata) begin
      bad++; $display("FAIL b2b_data: got %h want %h", rd, ref_rdata);
    end
  endtask

  task automatic test_random();
    int ns, st;
    logic [31:0] rd, a, d;
    bit w;
    for (int i = 0; i < 16; i++) begin
      a = ($urandom() & 32'hFFFF_FC00) | (32'(64 + i) << 2);
      run_access(1'b1, a, $urandom(), ns, rd, st);
    end
    for (int i = 0; i < 40; i++) begin
      w = $urandom_range(0, 1) == 1;
      a = ($urandom() & 32'hFFFF_FC00) | (32'(64 + $urandom_range(0, 15)) << 2);
      d = $urandom();
      run_access(w, a, d, ns, rd, st);
      total++;
      if (ns != 3 || rd !== ref_rdata) begin
        bad++;
        $display("FAIL rand%0d: got stall=%0d rdata=%h want 3 %h", i, ns, rd, ref_rdata);
      end
    end
  endtask

  initial begin
    idle();
    bus.addr  = '0;
    bus.wdata = '0;
    test_reset();
    test_write_read();
    test_wrap();
    test_illegal();
    test_reset_mid_write();
    test_perturb();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
